// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator/monitor pair.
package pulse_pkg;

  // Generator default period; the monitor defaults to the same value.
  localparam int unsigned DefaultPeriod = 5;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for the monitored pulse train, with an optional
// high-run (pulse width) detector enabled by PULSE_MONITOR_WIDTH_CHECK_EN.
module pulse_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic signal_in,
  output logic rise,
  output logic width_err
);

  logic sig_q;

  // Sampled through reset too, so a line held high at release is not an edge.
  always_ff @(posedge clk) begin
    sig_q <= signal_in;
  end

  assign rise = signal_in & ~sig_q;

`ifdef PULSE_MONITOR_WIDTH_CHECK_EN
  logic hi_run;
  logic run_d, run_q;

  assign hi_run = signal_in & sig_q;

  // run_q marks a high run that has already been reported.
  always_comb begin
    run_d = hi_run;
    if (reset) begin
      run_d = signal_in;
    end
  end

  always_ff @(posedge clk) begin
    run_q <= run_d;
  end

  assign width_err = hi_run & ~run_q & ~reset;
`else
  logic unused_reset;
  assign unused_reset = reset;
  assign width_err    = 1'b0;
`endif

endmodule

// File: rtl/pulse_monitor.sv
// Receive-side checker for the periodic pulse train: measures rising-edge
// intervals, tracks lock, flags mismatches/timeouts. Optional pulse width
// check is enabled by defining PULSE_MONITOR_WIDTH_CHECK_EN.
module pulse_monitor
  import pulse_pkg::*;
#(
  parameter int unsigned PERIOD     = DefaultPeriod,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             error,
  output logic [15:0]      pulse_count
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] PeriodVal   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GapMax      = {CNT_W{1'b1}};
  localparam logic [GoodW-1:0] LockVal     = GoodW'(LOCK_COUNT);

  logic rise;
  logic width_err;

  pulse_edge_detect u_edge_detect (
    .clk       (clk),
    .reset     (reset),
    .signal_in (signal_in),
    .rise      (rise),
    .width_err (width_err)
  );

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   gap_d, gap_q;
  logic [GoodW-1:0]   good_d, good_q;
  logic [CNT_W-1:0]   period_out_d, period_out_q;
  logic               period_valid_d, period_valid_q;
  logic               locked_d, locked_q;
  logic               error_d, error_q;
  logic [15:0]        pulse_count_d, pulse_count_q;

  logic               active;
  logic [CNT_W-1:0]   period;
  logic               period_ok;
  logic               timeout;

  assign active    = (state_q != StIdle);
  assign period    = gap_q + CNT_W'(1);
  assign period_ok = (period == PeriodVal);
  // A rise on the last gap cycle takes precedence over the timeout.
  assign timeout   = active && (gap_q == TimeoutLast) && !rise;

  always_comb begin
    state_d        = state_q;
    gap_d          = gap_q;
    good_d         = good_q;
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    error_d        = 1'b0;
    pulse_count_d  = pulse_count_q + 16'(rise);

    if (!active || rise) begin
      gap_d = '0;
    end else if (gap_q != GapMax) begin
      gap_d = gap_q + CNT_W'(1);
    end

    if (rise && active) begin
      period_valid_d = 1'b1;
      period_out_d   = period;
    end

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StAcquire;
          good_d  = '0;
        end
      end
      StAcquire: begin
        if (timeout) begin
          state_d = StIdle;
          good_d  = '0;
          error_d = 1'b1;
        end else if (rise && !period_ok) begin
          good_d  = '0;
          error_d = 1'b1;
        end else if (rise) begin
          good_d = good_q + GoodW'(1);
          if (good_d == LockVal) begin
            state_d = StLocked;
          end
        end
        if (width_err) begin
          good_d  = '0;
          error_d = 1'b1;
        end
      end
      StLocked: begin
        if (timeout) begin
          state_d = StIdle;
          good_d  = '0;
          error_d = 1'b1;
        end else if ((rise && !period_ok) || width_err) begin
          state_d = StAcquire;
          good_d  = '0;
          error_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        good_d  = '0;
      end
    endcase

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      gap_q          <= '0;
      good_q         <= '0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      error_q        <= 1'b0;
      pulse_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      good_q         <= good_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      error_q        <= error_d;
      pulse_count_q  <= pulse_count_d;
    end
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign error        = error_q;
  assign pulse_count  = pulse_count_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Self-checking bench for pulse_monitor; the width-check scenario runs only
// when PULSE_MONITOR_WIDTH_CHECK_EN is defined.
module tb_pulse_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        signal_in = 1'b0;
  logic [7:0]  period_out;
  logic        period_valid;
  logic        locked;
  logic        error;
  logic [15:0] pulse_count;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  int exp_q[$];

  pulse_monitor #(
    .PERIOD     (5),
    .CNT_W      (8),
    .LOCK_COUNT (4),
    .TIMEOUT    (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .signal_in    (signal_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .error        (error),
    .pulse_count  (pulse_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every period_valid strobe must match the next queued period.
  always @(negedge clk) begin
    if (error === 1'b1) err_cnt++;
    if (period_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_valid: got period_out=%0d, expected no strobe", period_out);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (period_out !== 8'(e)) begin
          miscompares++;
          $display("FAIL sb_period: got %0d, expected %0d", period_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hi();
    signal_in = 1'b1;
    tick();
    signal_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    signal_in = 1'b0;
    idle(3);
    vectors++;
    if (period_out !== 8'd0) begin
      miscompares++; $display("FAIL rst_period_out: got %0d, expected 0", period_out);
    end
    vectors++;
    if (period_valid !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_strobes: got valid=%b error=%b, expected 0 0", period_valid, error);
    end
    vectors++;
    if (locked !== 1'b0 || pulse_count !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_lock_count: got locked=%b count=%0d, expected 0 0", locked, pulse_count);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_train();
    int base;
    base = err_cnt;
    pulse_hi();
    vectors++;
    if (period_valid !== 1'b0) begin
      miscompares++; $display("FAIL good_first_no_valid: got %b, expected 0", period_valid);
    end
    idle(4);
    for (int i = 2; i <= 6; i++) begin
      exp_q.push_back(5);
      pulse_hi();
      if (i == 4) begin
        vectors++;
        if (locked !== 1'b0) begin
          miscompares++; $display("FAIL good_not_yet_locked: got %b, expected 0", locked);
        end
      end
      if (i == 5) begin
        vectors++;
        if (locked !== 1'b1) begin
          miscompares++; $display("FAIL good_locked_after_5th: got %b, expected 1", locked);
        end
      end
      idle(4);
    end
    vectors++;
    if (pulse_count !== 16'd6) begin
      miscompares++; $display("FAIL good_pulse_count: got %0d, expected 6", pulse_count);
    end
    vectors++;
    if (err_cnt != base) begin
      miscompares++; $display("FAIL good_no_error: got %0d errors, expected 0", err_cnt - base);
    end
  endtask

  task automatic test_mismatch();
    int base;
    base = err_cnt;
    idle(1);
    exp_q.push_back(6);
    pulse_hi();
    vectors++;
    if (period_valid !== 1'b1 || period_out !== 8'd6) begin
      miscompares++;
      $display("FAIL mis_period: got valid=%b period=%0d, expected 1 6", period_valid, period_out);
    end
    vectors++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_err_lock: got error=%b locked=%b, expected 1 0", error, locked);
    end
    idle(4);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(5);
      pulse_hi();
      if (i == 3) begin
        vectors++;
        if (locked !== 1'b0) begin
          miscompares++; $display("FAIL mis_relock_early: got %b, expected 0", locked);
        end
      end
      if (i == 4) begin
        vectors++;
        if (locked !== 1'b1) begin
          miscompares++; $display("FAIL mis_relock: got %b, expected 1", locked);
        end
      end
      idle(4);
    end
    vectors++;
    if (err_cnt - base != 1) begin
      miscompares++; $display("FAIL mis_error_count: got %0d, expected 1", err_cnt - base);
    end
  endtask

  // Entered 5 cycles after the last rise.
  task automatic test_timeout();
    int base;
    base = err_cnt;
    idle(5);
    vectors++;
    if (error !== 1'b0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL to_early: got error=%b locked=%b, expected 0 1", error, locked);
    end
    idle(1);
    vectors++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL to_strobe: got error=%b locked=%b, expected 1 0", error, locked);
    end
    idle(5);
    vectors++;
    if (err_cnt - base != 1) begin
      miscompares++; $display("FAIL to_error_count: got %0d, expected 1", err_cnt - base);
    end
    pulse_hi();
    vectors++;
    if (period_valid !== 1'b0) begin
      miscompares++; $display("FAIL to_idle_rise_valid: got %b, expected 0", period_valid);
    end
  endtask

  task automatic test_boundary();
    idle(9);
    exp_q.push_back(10);
    pulse_hi();
    vectors++;
    if (period_valid !== 1'b1 || period_out !== 8'd10) begin
      miscompares++;
      $display("FAIL bnd_period: got valid=%b period=%0d, expected 1 10", period_valid, period_out);
    end
    vectors++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL bnd_err_lock: got error=%b locked=%b, expected 1 0", error, locked);
    end
    idle(4);
    exp_q.push_back(5);
    pulse_hi();
    vectors++;
    if (period_valid !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL bnd_still_acquire: got valid=%b error=%b, expected 1 0", period_valid, error);
    end
    idle(4);
  endtask

  task automatic test_reset_mid_lock();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(5);
      pulse_hi();
      idle(4);
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++; $display("FAIL rml_locked: got %b, expected 1", locked);
    end
    reset = 1'b1;
    signal_in = 1'b1;
    tick();
    vectors++;
    if (locked !== 1'b0 || error !== 1'b0 || period_valid !== 1'b0 ||
        period_out !== 8'd0 || pulse_count !== 16'd0) begin
      miscompares++;
      $display("FAIL rml_cleared: got locked=%b error=%b valid=%b period=%0d count=%0d, expected all 0",
               locked, error, period_valid, period_out, pulse_count);
    end
    reset = 1'b0;
    idle(3);
    vectors++;
    if (pulse_count !== 16'd0 || period_valid !== 1'b0 || error !== 1'b0 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL rml_held_high: got count=%0d valid=%b error=%b locked=%b, expected 0 0 0 0",
               pulse_count, period_valid, error, locked);
    end
    signal_in = 1'b0;
    idle(2);
  endtask

`ifdef PULSE_MONITOR_WIDTH_CHECK_EN
  task automatic test_width();
    int base;
    int pc;
    pulse_hi();
    idle(4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(5);
      pulse_hi();
      idle(4);
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++; $display("FAIL wid_locked: got %b, expected 1", locked);
    end
    base = err_cnt;
    pc = pulse_count;
    exp_q.push_back(5);
    signal_in = 1'b1;
    tick();
    tick();
    vectors++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL wid_err_lock: got error=%b locked=%b, expected 1 0", error, locked);
    end
    signal_in = 1'b0;
    idle(4);
    vectors++;
    if (pulse_count !== 16'(pc + 1) || err_cnt - base != 1) begin
      miscompares++;
      $display("FAIL wid_counts: got count=%0d errors=%0d, expected %0d 1",
               pulse_count, err_cnt - base, pc + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_train();
    test_mismatch();
    test_timeout();
    test_boundary();
    test_reset_mid_lock();
`ifdef PULSE_MONITOR_WIDTH_CHECK_EN
    test_width();
`endif
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_monitor.md
Name: pulse_monitor

Overview:
Receive-side checker for the periodic one-cycle pulse train made by the team's pulse generator. It sits in the same clock domain. It measures the interval between rising edges and compares it against the expected period. It declares lock after a run of good intervals and flags period errors and pulse loss. Status outputs feed the test/diagnostic logic.

Parameters:
PERIOD, 5, expected cycles between successive rising edges (generator default)
CNT_W, 8, width of the interval counter and period_out
LOCK_COUNT, 4, consecutive good intervals required to assert locked
TIMEOUT, 10, cycles without a rising edge before lock is dropped; must be > PERIOD and < 2**CNT_W

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
signal_in  input  1  pulse train from the generator, same clock domain
period_out  output  CNT_W  last measured rising-edge interval in cycles
period_valid  output  1  one-cycle strobe; period_out updated this cycle
locked  output  1  level; pulse train matches PERIOD
error  output  1  one-cycle strobe on a period mismatch or timeout
pulse_count  output  16  number of rising edges since reset; wraps 0xFFFF->0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - period_out=0, period_valid=0, locked=0, error=0, pulse_count=0.
  - gap=0, good_cnt=0, state=IDLE.
  - sig_q samples signal_in during reset, so an input held high at reset release is not counted as an edge.
- Edge detection: rise = signal_in & ~sig_q; sig_q <= signal_in every cycle.
- Gap counter:
  - Cleared to 0 on rise; otherwise increments, saturating at 2**CNT_W-1.
  - Measured period = gap+1, so a pulse every 5 cycles measures 5.
- Timing: all outputs are registered. Strobes and state changes appear the cycle after the rise or timeout cycle.
- State machine, states IDLE, ACQUIRE, LOCKED:
  - IDLE:
    - gap is held at 0 and no timeout fires.
    - On the first rise: go to ACQUIRE with good_cnt=0. No period_valid, because there is no reference edge yet.
  - ACQUIRE:
    - Rise with period==PERIOD: good_cnt++; when good_cnt reaches LOCK_COUNT, go to LOCKED.
    - Rise with a mismatch: good_cnt=0, error strobe.
    - Timeout: go to IDLE, error strobe.
  - LOCKED:
    - locked=1.
    - Mismatch: go to ACQUIRE with good_cnt=0, error strobe, locked=0.
    - Timeout: go to IDLE, error strobe, locked=0.
- Timeout event: in ACQUIRE or LOCKED, gap==TIMEOUT-1 and no rise this cycle.
- Simultaneous events: a rise on the timeout cycle wins. It measures period TIMEOUT, which is a mismatch.
- Strobes:
  - Every rise outside IDLE gives period_valid and period_out=gap+1, whether the period is good or not.
  - pulse_count increments on every rise, including in IDLE.
- Reset mid-operation: everything returns to the reset values the next cycle, including dropping locked.

Optional Feature:
- Macro: PULSE_MONITOR_WIDTH_CHECK_EN.
- Defined:
  - signal_in high for 2+ consecutive cycles asserts error once, on the cycle after the second high cycle.
  - It forces LOCKED->ACQUIRE with good_cnt=0.
  - It does not increment pulse_count.
- Undefined: pulse width is ignored; only rising edges matter.

Decomposition:
- Shared package pulse_pkg:
  - State enum (IDLE, ACQUIRE, LOCKED).
  - Default PERIOD constant shared with the generator, so both ends agree.
- One natural sub-module, pulse_edge_detect: sig_q register, rise output, and the optional high-run detector.

Test Plan:
- Good train: generator-style pulse every 5 cycles from reset release.
  - First period_valid follows the 2nd rise with period_out=5.
  - locked=1 the cycle after the 5th rise.
  - error never asserts.
- Mismatch: with the monitor locked, one interval of 6.
  - period_valid with period_out=6, a single error strobe, locked=0.
  - Then 4 further good intervals restore locked.
- Timeout: with the monitor locked, stop pulses.
  - 10 cycles after the last rise, error strobes once, locked=0, state is IDLE.
  - The next rise gives no period_valid.
- Reset mid-lock: assert reset for 1 cycle while locked.
  - All outputs are 0 the next cycle.
  - signal_in held high across reset release gives no rise and pulse_count stays 0.
- Boundary: a rise exactly on the timeout cycle gives period_out=10 plus an error strobe, and state is ACQUIRE, not IDLE.
- With PULSE_MONITOR_WIDTH_CHECK_EN: a 2-cycle-high pulse while locked gives one error, locked=0, and pulse_count incremented once.
